// File: rtl/sprime_block_writer_pkg.sv
// Shared constants and types for the S' block writer.
// Holds the FSM state enum, the colour-segment enum, per-segment SRAM offsets, row strides and
// block-grid geometry, plus small lookup helpers keyed by segment.
package sprime_block_writer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StWrHi,
    StWrLo,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    SegY = 2'd0,
    SegU = 2'd1,
    SegV = 2'd2
  } seg_e;

  localparam int unsigned AddrW = 18;

  localparam logic [AddrW-1:0] OffsetY  = 18'd0;
  localparam logic [AddrW-1:0] OffsetU  = 18'd76800;
  localparam logic [AddrW-1:0] OffsetV  = 18'd115200;
  localparam logic [AddrW-1:0] StrideY  = 18'd320;
  localparam logic [AddrW-1:0] StrideUV = 18'd160;

  localparam logic [5:0] BlkColsY  = 6'd40;
  localparam logic [5:0] BlkColsUV = 6'd20;
  localparam logic [4:0] BlkRows   = 5'd30;

  // Last DPRAM word of a block (32 words of two coefficients each).
  localparam logic [4:0] LastWord = 5'd31;

  function automatic logic [AddrW-1:0] seg_offset(seg_e seg);
    case (seg)
      SegY:    return OffsetY;
      SegU:    return OffsetU;
      SegV:    return OffsetV;
      default: return OffsetY;
    endcase
  endfunction

  function automatic logic [AddrW-1:0] seg_stride(seg_e seg);
    return (seg == SegY) ? StrideY : StrideUV;
  endfunction

  function automatic logic [5:0] seg_last_cb(seg_e seg);
    return (seg == SegY) ? (BlkColsY - 6'd1) : (BlkColsUV - 6'd1);
  endfunction

endpackage

// File: rtl/sprime_addr_gen.sv
// SRAM word-address generator for one coefficient of an 8x8 block.
// addr = seg_base + segment offset + (rb*8 + r) * stride + cb*8 + c, all 18-bit unsigned.
// Ports:
//   seg_i      segment (Y/U/V)
//   rb_i, cb_i block row / block column within the segment
//   r_i, c_i   row / column inside the 8x8 block
//   seg_base_i SRAM word address of the Y segment origin
//   addr_o     resulting SRAM word address (combinational)
module sprime_addr_gen
  import sprime_block_writer_pkg::*;
(
  input  seg_e             seg_i,
  input  logic [4:0]       rb_i,
  input  logic [5:0]       cb_i,
  input  logic [2:0]       r_i,
  input  logic [2:0]       c_i,
  input  logic [AddrW-1:0] seg_base_i,
  output logic [AddrW-1:0] addr_o
);

  logic [AddrW-1:0] row;
  logic [AddrW-1:0] col;

  always_comb begin
    // {rb, r} is rb*8 + r; {cb, c} is cb*8 + c.
    row    = {10'd0, rb_i, r_i};
    col    = {9'd0, cb_i, c_i};
    addr_o = seg_base_i + seg_offset(seg_i) + row * seg_stride(seg_i) + col;
  end

endmodule

// File: rtl/sprime_block_writer.sv
// Writes one 64-coefficient 8x8 block from the dual-port RAM into SRAM, in the raster layout
// the S' fetch path reads back. Blocks are emitted in Y, U, V order, raster over block columns
// then block rows; after the last V block the writer latches WP_memory_end.
// Ports:
//   CLOCK_50_I       clock, rising edge
//   Reset            synchronous active-high reset
//   WP_start         pulse: write the current block (ignored unless idle and not at memory end)
//   SEG_BASE         Y segment origin, captured on an accepted WP_start
//   DP_read_address  DPRAM word address (0..31)
//   DP_read_data     DPRAM data, valid one cycle after the address
//   SRAM_address     registered SRAM word address
//   SRAM_write_data  registered SRAM write data
//   SRAM_we_n        registered SRAM write enable, active low
//   WP_done          pulse: block fully written
//   WP_memory_end    level: last V block written
module sprime_block_writer
  import sprime_block_writer_pkg::*;
(
  input  logic             CLOCK_50_I,
  input  logic             Reset,
  input  logic             WP_start,
  input  logic [AddrW-1:0] SEG_BASE,
  output logic [6:0]       DP_read_address,
  input  logic [31:0]      DP_read_data,
  output logic [AddrW-1:0] SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  output logic             WP_done,
  output logic             WP_memory_end
);

  state_e           state_q;
  seg_e             seg_q;
  logic [5:0]       cb_q;
  logic [4:0]       rb_q;
  logic [4:0]       word_q;
  logic [AddrW-1:0] seg_base_q;
  logic [6:0]       rd_addr_q;
  logic [AddrW-1:0] sram_addr_q;
  logic [15:0]      sram_data_q;
  logic             we_n_q;
  logic             done_q;
  logic             mem_end_q;

  logic             lo_half;
  logic [AddrW-1:0] wr_addr;

  // Word k holds row k/4, columns 2*(k%4) (high half) and 2*(k%4)+1 (low half).
  assign lo_half = (state_q == StWrLo);

  sprime_addr_gen u_addr_gen (
    .seg_i      (seg_q),
    .rb_i       (rb_q),
    .cb_i       (cb_q),
    .r_i        (word_q[4:2]),
    .c_i        ({word_q[1:0], lo_half}),
    .seg_base_i (seg_base_q),
    .addr_o     (wr_addr)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q     <= StIdle;
      seg_q       <= SegY;
      cb_q        <= '0;
      rb_q        <= '0;
      word_q      <= '0;
      seg_base_q  <= '0;
      rd_addr_q   <= '0;
      sram_addr_q <= '0;
      sram_data_q <= '0;
      we_n_q      <= 1'b1;
      done_q      <= 1'b0;
      mem_end_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      we_n_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (WP_start && !mem_end_q) begin
            state_q    <= StLead;
            rd_addr_q  <= '0;
            word_q     <= '0;
            seg_base_q <= SEG_BASE;
          end
        end
        // Word 0 is in flight through the registered DPRAM.
        StLead: state_q <= StWrHi;
        StWrHi: begin
          sram_addr_q <= wr_addr;
          sram_data_q <= DP_read_data[31:16];
          we_n_q      <= 1'b0;
          // The new address only reaches the DPRAM output after WR_LO, so the current word
          // stays valid for the low half.
          if (word_q != LastWord) begin
            rd_addr_q <= {2'b00, word_q + 5'd1};
          end
          state_q <= StWrLo;
        end
        StWrLo: begin
          sram_addr_q <= wr_addr;
          sram_data_q <= DP_read_data[15:0];
          we_n_q      <= 1'b0;
          if (word_q == LastWord) begin
            state_q <= StDone;
          end else begin
            word_q  <= word_q + 5'd1;
            state_q <= StWrHi;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (cb_q == seg_last_cb(seg_q)) begin
            cb_q <= '0;
            if (rb_q == BlkRows - 5'd1) begin
              rb_q <= '0;
              if (seg_q == SegV) begin
                mem_end_q <= 1'b1;
              end else begin
                seg_q <= (seg_q == SegY) ? SegU : SegV;
              end
            end else begin
              rb_q <= rb_q + 5'd1;
            end
          end else begin
            cb_q <= cb_q + 6'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign DP_read_address = rd_addr_q;
  assign SRAM_address    = sram_addr_q;
  assign SRAM_write_data = sram_data_q;
  assign SRAM_we_n       = we_n_q;
  assign WP_done         = done_q;
  assign WP_memory_end   = mem_end_q;

endmodule

// File: tb/tb_sprime_block_writer.sv
// Scoreboard bench for sprime_block_writer: stimulus pushes expected SRAM writes (address, data,
// cycle) and expected WP_done cycles; a negedge monitor pops and compares.
module tb_sprime_block_writer;
  import sprime_block_writer_pkg::*;

  logic        clk;
  logic        Reset;
  logic        WP_start;
  logic [17:0] SEG_BASE;
  logic [6:0]  DP_read_address;
  logic [31:0] DP_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic        WP_done;
  logic        WP_memory_end;

  sprime_block_writer dut (
    .CLOCK_50_I      (clk),
    .Reset           (Reset),
    .WP_start        (WP_start),
    .SEG_BASE        (SEG_BASE),
    .DP_read_address (DP_read_address),
    .DP_read_data    (DP_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .WP_done         (WP_done),
    .WP_memory_end   (WP_memory_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle k is the interval after rising edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered dual-port RAM model.
  logic [31:0] dpram [128];
  always @(posedge clk) DP_read_data <= dpram[DP_read_address];

  typedef struct {
    logic [17:0] addr;
    logic [15:0] data;
    int          cyc;
    bit          first;
  } exp_wr_t;

  exp_wr_t     wq[$];
  int          dq[$];
  int          checks = 0;
  int          errors = 0;
  logic [17:0] first_addr;
  logic [17:0] last_addr;
  exp_wr_t     mon_e;
  int          mon_d;

  // Reference block position.
  int m_seg = 0;
  int m_rb  = 0;
  int m_cb  = 0;
  int serial = 0;

  function automatic int seg_off_m(int s);
    return (s == 0) ? 0 : (s == 1) ? 76800 : 115200;
  endfunction

  function automatic int seg_stride_m(int s);
    return (s == 0) ? 320 : 160;
  endfunction

  function automatic int seg_cols_m(int s);
    return (s == 0) ? 40 : 20;
  endfunction

  function automatic logic [31:0] dp_word(int k, logic [15:0] salt);
    logic [15:0] hi;
    logic [15:0] lo;
    hi = (16'h0011 + 16'(k * 256)) ^ salt;
    lo = (16'h0022 + 16'(k * 256)) ^ salt;
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic adv_model();
    m_cb++;
    if (m_cb == seg_cols_m(m_seg)) begin
      m_cb = 0;
      m_rb++;
      if (m_rb == 30) begin
        m_rb = 0;
        if (m_seg < 2) m_seg++;
      end
    end
  endtask

  // Issues WP_start at the next edge (edge n) and queues the first nwr expected writes.
  task automatic run_block(input int base, input int nwr, input bit want_done, output int n);
    logic [15:0] salt;
    logic [31:0] w;
    exp_wr_t     e;
    @(negedge clk);
    salt = 16'(serial * 37);
    serial++;
    for (int k = 0; k < 32; k++) dpram[k] = dp_word(k, salt);
    first_addr = '1;
    WP_start = 1'b1;
    SEG_BASE = 18'(base);
    n = cyc + 1;
    for (int i = 0; i < nwr; i++) begin
      int k, h, r, c;
      k = i / 2;
      h = i % 2;
      r = k / 4;
      c = 2 * (k % 4) + h;
      w = dp_word(k, salt);
      e.addr  = 18'(base + seg_off_m(m_seg) + (m_rb * 8 + r) * seg_stride_m(m_seg)
                    + m_cb * 8 + c);
      e.data  = h ? w[15:0] : w[31:16];
      e.cyc   = n + 2 + i;
      e.first = (i == 0);
      wq.push_back(e);
    end
    if (want_done) begin
      dq.push_back(n + 66);
      adv_model();
    end
    @(negedge clk);
    WP_start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 150 && (wq.size() != 0 || dq.size() != 0); i++) @(negedge clk);
    if (wq.size() != 0 || dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending writes %0d, pending done %0d, required 0 and 0",
               wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
  endtask

  always @(negedge clk) begin
    if (SRAM_we_n === 1'b0) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%h at cycle %0d, required no write",
                 SRAM_address, SRAM_write_data, cyc);
      end else begin
        mon_e = wq.pop_front();
        checks++;
        if (SRAM_address !== mon_e.addr || SRAM_write_data !== mon_e.data || cyc != mon_e.cyc)
        begin
          errors++;
          $display("FAIL sram_write: got addr %0d data 0x%h cycle %0d, required addr %0d data 0x%h cycle %0d",
                   SRAM_address, SRAM_write_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
        if (mon_e.first) first_addr = SRAM_address;
        last_addr = SRAM_address;
      end
    end
    if (WP_done === 1'b1) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: WP_done at cycle %0d, required none", cyc);
      end else begin
        mon_d = dq.pop_front();
        checks++;
        if (cyc != mon_d) begin
          errors++;
          $display("FAIL done_cycle: got cycle %0d required cycle %0d", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    int n;
    Reset    = 1'b1;
    WP_start = 1'b0;
    SEG_BASE = '0;
    for (int k = 0; k < 128; k++) dpram[k] = '0;
    repeat (3) @(negedge clk);
    check("rst_we_n", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_data", 32'(SRAM_write_data), 32'd0);
    check("rst_dp_addr", 32'(DP_read_address), 32'd0);
    check("rst_done", 32'(WP_done), 32'd0);
    check("rst_mem_end", 32'(WP_memory_end), 32'd0);
    Reset = 1'b0;

    // Block 0: word0 0x0011_0022 lands at 76800/76801, word4 at 77120.
    run_block(76800, 64, 1'b1, n);
    drain();
    check("blk0_first_addr", 32'(first_addr), 32'd76800);

    // Block 1 with a stray WP_start at edge n+10 that must be ignored.
    run_block(76800, 64, 1'b1, n);
    while (cyc < n + 9) @(negedge clk);
    WP_start = 1'b1;
    @(negedge clk);
    WP_start = 1'b0;
    drain();
    check("blk1_first_addr", 32'(first_addr), 32'd76808);

    // Blocks 2..40; block 40 is RB=1, CB=0.
    for (int b = 2; b <= 40; b++) begin
      run_block(76800, 64, 1'b1, n);
      drain();
    end
    check("blk40_first_addr", 32'(first_addr), 32'd79360);

    // Jump to the last Y block (RB=29, CB=39), then cross into U.
    @(negedge clk);
    force dut.cb_q = 6'd39;
    force dut.rb_q = 5'd29;
    force dut.seg_q = SegY;
    @(negedge clk);
    release dut.cb_q;
    release dut.rb_q;
    release dut.seg_q;
    m_seg = 0; m_rb = 29; m_cb = 39;
    run_block(76800, 64, 1'b1, n);
    drain();
    check("blk1199_last_addr", 32'(last_addr), 32'd153599);
    run_block(76800, 64, 1'b1, n);
    drain();
    check("blk1200_first_addr", 32'(first_addr), 32'd153600);

    // Jump to the last U block, then cross into V.
    @(negedge clk);
    force dut.cb_q = 6'd19;
    force dut.rb_q = 5'd29;
    force dut.seg_q = SegU;
    @(negedge clk);
    release dut.cb_q;
    release dut.rb_q;
    release dut.seg_q;
    m_seg = 1; m_rb = 29; m_cb = 19;
    run_block(76800, 64, 1'b1, n);
    drain();
    run_block(76800, 64, 1'b1, n);
    drain();
    check("blk1800_first_addr", 32'(first_addr), 32'd192000);

    // Last two V blocks; WP_memory_end rises with WP_done on the final one.
    @(negedge clk);
    force dut.cb_q = 6'd18;
    force dut.rb_q = 5'd29;
    force dut.seg_q = SegV;
    @(negedge clk);
    release dut.cb_q;
    release dut.rb_q;
    release dut.seg_q;
    m_seg = 2; m_rb = 29; m_cb = 18;
    run_block(76800, 64, 1'b1, n);
    drain();
    check("blk2398_mem_end", 32'(WP_memory_end), 32'd0);
    run_block(76800, 64, 1'b1, n);
    while (cyc < n + 65) @(negedge clk);
    check("mem_end_before_done", 32'(WP_memory_end), 32'd0);
    @(negedge clk);
    check("mem_end_at_done", 32'(WP_memory_end), 32'd1);
    drain();
    check("blk2399_last_addr", 32'(last_addr), 32'd230399);

    // WP_start after memory end: no writes, no done.
    @(negedge clk);
    WP_start = 1'b1;
    @(negedge clk);
    WP_start = 1'b0;
    repeat (80) @(negedge clk);
    check("mem_end_held", 32'(WP_memory_end), 32'd1);

    // Full reset, one normal block, then a reset in the middle of the next block.
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    m_seg = 0; m_rb = 0; m_cb = 0;
    check("mem_end_cleared", 32'(WP_memory_end), 32'd0);
    run_block(76800, 64, 1'b1, n);
    drain();
    check("post_rst_blk0_first", 32'(first_addr), 32'd76800);
    run_block(76800, 19, 1'b0, n);
    while (cyc < n + 20) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("mid_rst_we_n", 32'(SRAM_we_n), 32'd1);
    m_seg = 0; m_rb = 0; m_cb = 0;
    drain();
    repeat (70) @(negedge clk);
    run_block(76800, 64, 1'b1, n);
    drain();
    check("restart_first_addr", 32'(first_addr), 32'd76800);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprime_block_writer.md
SPRIME_BLOCK_WRITER -- requirements
Module: sprime_block_writer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; parameter: none, all geometry is fixed by package constants.
REQ-002 CLOCK_50_I  in  1  sole clock; all logic on rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 WP_start  in  1  one-cycle pulse: write the current 8x8 block.
REQ-005 SEG_BASE  in  18  SRAM word address of the Y segment origin; sampled on each accepted WP_start.
REQ-006 DP_read_address  out  7  dual-port RAM read address (0..31 used).
REQ-007 DP_read_data  in  32  dual-port RAM read data, registered, valid one cycle after the address.
REQ-008 SRAM_address  out  18  SRAM word address.
REQ-009 SRAM_write_data  out  16  SRAM write data.
REQ-010 SRAM_we_n  out  1  SRAM write enable, active low.
REQ-011 WP_done  out  1  one-cycle pulse: block fully written.
REQ-012 WP_memory_end  out  1  level: last V block written.

Function
REQ-013 Purpose: writer counterpart of the S' fetch path; writes one 64-coefficient block from the dual-port RAM into SRAM in the layout the fetch path reads.
REQ-014 DPRAM word k (0..31) = row k/4, columns 2*(k%4) (bits 31:16) and 2*(k%4)+1 (bits 15:0).
REQ-015 SRAM address = SEG_BASE + seg_offset + (RB*8+r)*stride + CB*8 + c; Y: offset 0, stride 320, 40 block columns; U: offset 76800, stride 160, 20 block columns; V: offset 115200, stride 160, 20 block columns; 30 block rows each.
REQ-016 States: IDLE, LEAD, WR_HI, WR_LO, DONE.
REQ-017 IDLE: SRAM_we_n=1; WP_start=1 and WP_memory_end=0 -> LEAD, DP_read_address=0.
REQ-018 LEAD: one cycle, waits DPRAM latency -> WR_HI.
REQ-019 WR_HI: write bits 31:16 to column 2j, SRAM_we_n=0; issue next DPRAM read -> WR_LO.
REQ-020 WR_LO: write bits 15:0 to column 2j+1, SRAM_we_n=0; after word 31 -> DONE, else -> WR_HI.
REQ-021 DONE: WP_done=1 for one cycle, advance CB/RB/segment -> IDLE.
REQ-022 Latency: WP_start sampled at edge N; first write cycle N+2; 64 consecutive write cycles, last N+65; WP_done high in cycle N+66.
REQ-023 SRAM_address, SRAM_write_data, SRAM_we_n SHALL be registered; no SRAM write outside WR_HI/WR_LO.
REQ-024 Wrap: CB wraps at segment column count and increments RB; RB wraps at 30 and advances Y->U->V.
REQ-025 After block 2399 (V, RB=29, CB=19) WP_memory_end SHALL go high in the DONE cycle and stay high until reset.
REQ-026 WP_start while not IDLE SHALL be ignored; WP_start while WP_memory_end=1 SHALL be ignored and produce no WP_done.
REQ-027 Address arithmetic SHALL be 18-bit unsigned; largest address 230399 fits without overflow.

Reset
REQ-028 Reset SHALL force IDLE, CB=RB=0, segment=Y, SRAM_we_n=1, SRAM_address=0, SRAM_write_data=0, DP_read_address=0, WP_done=0, WP_memory_end=0.
REQ-029 Reset mid-block SHALL deassert SRAM_we_n in the following cycle and discard the partial block, with no WP_done.

Structure
REQ-030 Shared package SHALL hold the state enum, segment enum, segment offsets, strides, block column counts (40/20) and block row count (30).
REQ-031 Address computation SHALL live in one sub-module, sprime_addr_gen (inputs: segment, RB, CB, r, c, SEG_BASE; output: 18-bit address).

Verification
REQ-032 SEG_BASE=76800, block 0, word0=0x0011_0022 -> SRAM[76800]=0x0011, SRAM[76801]=0x0022; word4 -> SRAM[77120]; WP_done at N+66.
REQ-033 Second WP_start -> first write at SRAM[76808]; 41st block (RB=1, CB=0) -> first write at SRAM[79360].
REQ-034 1201st block -> first write at SRAM[153600] (U); 1801st -> SRAM[192000] (V); 2400th -> WP_memory_end=1, next WP_start gives no write.
REQ-035 WP_start pulsed again at cycle N+10 -> ignored; exactly 64 writes, one WP_done.
REQ-036 Reset asserted at cycle N+20 -> SRAM_we_n=1 from N+21, no WP_done, next block restarts at SRAM[76800].
